// File: rtl/cipher_pkg.sv
// Shared types and constants for the cipher datapath.
// Holds the message packer state encoding and block geometry.
package cipher_pkg;

    typedef enum logic [1:0] {
        FILL,
        EMIT,
        PAD,
        DONE
    } pack_state_e;

    localparam int BLOCK_WORDS = 16;
    localparam int WORD_BYTES  = 4;
    localparam int BLOCK_BYTES = 64;

endpackage

// File: rtl/msg_block_packer.sv
// Byte-serial to 32-bit little-endian word packer for the cipher data port.
// Groups words into blocks, zero-pads the final block and reports lengths.
module msg_block_packer #(
    parameter int         BLOCK_WORDS = cipher_pkg::BLOCK_WORDS,
    parameter int         LEN_W       = 32,
    parameter logic [7:0] PAD_BYTE    = 8'h00
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    input  logic [7:0]       in_byte,
    input  logic             in_byte_valid,
    input  logic             in_byte_last,
    output logic             in_byte_ready,
    output logic [31:0]      blk_word,
    output logic             blk_word_valid,
    output logic             blk_word_last,
    input  logic             blk_word_ready,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] msg_len_bytes,
    output logic [6:0]       last_blk_bytes
);
    import cipher_pkg::*;

    localparam int WP_W = $clog2(BLOCK_WORDS);
    localparam logic [31:0] PAD_WORD = {4{PAD_BYTE}};

    pack_state_e      state_q, state_d;
    logic [1:0]       byte_ptr_q, byte_ptr_d;
    logic [WP_W-1:0]  word_ptr_q, word_ptr_d;
    logic [31:0]      buf_q, buf_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic             last_seen_q, last_seen_d;
    logic             busy_q, busy_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [6:0]       lb_q, lb_d;
    logic             wp_last;

    assign wp_last        = (word_ptr_q == WP_W'(BLOCK_WORDS - 1));
    assign busy           = busy_q;
    assign msg_len_bytes  = len_q;
    assign last_blk_bytes = lb_q;

    always_comb begin
        state_d        = state_q;
        byte_ptr_d     = byte_ptr_q;
        word_ptr_d     = word_ptr_q;
        buf_d          = buf_q;
        count_d        = count_q;
        last_seen_d    = last_seen_q;
        busy_d         = busy_q;
        len_d          = len_q;
        lb_d           = lb_q;
        in_byte_ready  = 1'b0;
        blk_word       = '0;
        blk_word_valid = 1'b0;
        blk_word_last  = 1'b0;
        done           = 1'b0;
        unique case (state_q)
            FILL: begin
                in_byte_ready = 1'b1;
                if (in_byte_valid) begin
                    buf_d[{byte_ptr_q, 3'b000} +: 8] = in_byte;
                    count_d = count_q + LEN_W'(1);
                    busy_d  = 1'b1;
                    if (byte_ptr_q == 2'd3 || in_byte_last) begin
                        state_d     = EMIT;
                        last_seen_d = in_byte_last;
                    end else begin
                        byte_ptr_d = byte_ptr_q + 2'd1;
                    end
                end
            end
            EMIT: begin
                blk_word_valid = 1'b1;
                blk_word       = buf_q;
                blk_word_last  = last_seen_q && wp_last;
                if (blk_word_ready) begin
                    word_ptr_d = wp_last ? '0 : word_ptr_q + WP_W'(1);
                    byte_ptr_d = '0;
                    buf_d      = PAD_WORD;
                    if (!last_seen_q) begin
                        state_d = FILL;
                    end else if (wp_last) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                blk_word_valid = 1'b1;
                blk_word       = PAD_WORD;
                blk_word_last  = wp_last;
                if (blk_word_ready) begin
                    if (wp_last) begin
                        state_d    = DONE;
                        busy_d     = 1'b0;
                        word_ptr_d = '0;
                    end else begin
                        word_ptr_d = word_ptr_q + WP_W'(1);
                    end
                end
            end
            DONE: begin
                done        = 1'b1;
                len_d       = count_q;
                // Low 6 bits of count-1, plus one, gives 1..64 even on wrap.
                lb_d        = {1'b0, 6'(count_q - LEN_W'(1))} + 7'd1;
                count_d     = '0;
                word_ptr_d  = '0;
                last_seen_d = 1'b0;
                state_d     = FILL;
            end
            default: state_d = FILL;
        endcase
        if (abort) begin
            state_d     = FILL;
            byte_ptr_d  = '0;
            word_ptr_d  = '0;
            buf_d       = PAD_WORD;
            count_d     = '0;
            last_seen_d = 1'b0;
            busy_d      = 1'b0;
            len_d       = len_q;
            lb_d        = lb_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            byte_ptr_q  <= '0;
            word_ptr_q  <= '0;
            buf_q       <= PAD_WORD;
            count_q     <= '0;
            last_seen_q <= 1'b0;
            busy_q      <= 1'b0;
            len_q       <= '0;
            lb_q        <= '0;
        end else begin
            state_q     <= state_d;
            byte_ptr_q  <= byte_ptr_d;
            word_ptr_q  <= word_ptr_d;
            buf_q       <= buf_d;
            count_q     <= count_d;
            last_seen_q <= last_seen_d;
            busy_q      <= busy_d;
            len_q       <= len_d;
            lb_q        <= lb_d;
        end
    end

endmodule

// File: tb/tb_msg_block_packer.sv
// Self-checking bench for msg_block_packer: table vectors, corner sequences
// and randomized messages checked against a byte-array reference model.
module tb_msg_block_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        abort;
    logic [7:0]  in_byte;
    logic        in_byte_valid;
    logic        in_byte_last;
    logic        in_byte_ready;
    logic [31:0] blk_word;
    logic        blk_word_valid;
    logic        blk_word_last;
    logic        blk_word_ready = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] msg_len_bytes;
    logic [6:0]  last_blk_bytes;

    msg_block_packer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .abort          (abort),
        .in_byte        (in_byte),
        .in_byte_valid  (in_byte_valid),
        .in_byte_last   (in_byte_last),
        .in_byte_ready  (in_byte_ready),
        .blk_word       (blk_word),
        .blk_word_valid (blk_word_valid),
        .blk_word_last  (blk_word_last),
        .blk_word_ready (blk_word_ready),
        .busy           (busy),
        .done           (done),
        .msg_len_bytes  (msg_len_bytes),
        .last_blk_bytes (last_blk_bytes)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  msg_q[$];
    logic [32:0] got_q[$];
    logic [32:0] exp_q[$];
    logic        rand_ready  = 1'b0;
    logic        force_ready = 1'b1;
    int          gap_pct     = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Single driver for the downstream ready.
    always @(posedge clk) begin
        #1;
        blk_word_ready = rand_ready ? ($urandom_range(0, 99) < 70) : force_ready;
    end

    logic        prev_stall = 1'b0;
    logic [32:0] prev_w;
    always @(negedge clk) begin
        if (!rst_n || abort) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("hold", {blk_word_valid, blk_word_last, blk_word},
                    {1'b1, prev_w});
            if (blk_word_valid && blk_word_ready)
                got_q.push_back({blk_word_last, blk_word});
            prev_stall = blk_word_valid && !blk_word_ready;
            prev_w     = {blk_word_last, blk_word};
        end
    end

    // Reference: pad the byte array to whole 64-byte blocks, pack LE words.
    task automatic build_exp();
        int n;
        int nw;
        exp_q.delete();
        n  = msg_q.size();
        nw = ((n + 63) / 64) * 16;
        for (int w = 0; w < nw; w++) begin
            logic [31:0] word;
            word = '0;
            for (int b = 0; b < 4; b++) begin
                int idx;
                idx = w * 4 + b;
                if (idx < n) word[b*8 +: 8] = msg_q[idx];
            end
            exp_q.push_back({w == nw - 1, word});
        end
    endtask

    task automatic send_bytes(input bit mark_last);
        for (int i = 0; i < msg_q.size(); i++) begin
            int t;
            if ($urandom_range(0, 99) < gap_pct) begin
                @(posedge clk);
                #1;
            end
            in_byte       = msg_q[i];
            in_byte_valid = 1'b1;
            in_byte_last  = mark_last && (i == msg_q.size() - 1);
            t = 0;
            while (1) begin
                @(negedge clk);
                if (in_byte_ready) break;
                t++;
                if (t > 500) begin
                    chk("byte_timeout", 1, 0);
                    break;
                end
            end
            @(posedge clk);
            #1;
            in_byte_valid = 1'b0;
            in_byte_last  = 1'b0;
        end
    endtask

    task automatic finish_msg(string name, int exp_nw, int exp_lb);
        int t;
        int n;
        t = 0;
        while (1) begin
            @(negedge clk);
            if (done) break;
            t++;
            if (t > 3000) begin
                chk({name, "_done_timeout"}, 1, 0);
                break;
            end
        end
        chk({name, "_busy_at_done"}, busy, 0);
        @(negedge clk);
        chk({name, "_done_pulse"}, done, 0);
        chk({name, "_len"}, msg_len_bytes, msg_q.size());
        chk({name, "_last_blk"}, last_blk_bytes, exp_lb);
        chk({name, "_nwords"}, got_q.size(), exp_nw);
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_w%0d", name, i), got_q[i], exp_q[i]);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          len;
        int          nwords;
        int          lb;
        int          idx;
        logic [32:0] val;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int saved_len;
        int saved_lb;
        int t;
        vecs[0] = '{3,   16, 3,  0,  {1'b0, 32'h00332211}};
        vecs[1] = '{64,  16, 64, 15, {1'b1, 32'h3F3E3D3C}};
        vecs[2] = '{65,  32, 1,  16, {1'b0, 32'h00000040}};
        vecs[3] = '{1,   16, 1,  15, {1'b1, 32'h00000000}};
        vecs[4] = '{4,   16, 4,  0,  {1'b0, 32'h03020100}};
        vecs[5] = '{63,  16, 63, 15, {1'b1, 32'h003E3D3C}};
        vecs[6] = '{128, 32, 64, 31, {1'b1, 32'h7F7E7D7C}};
        vecs[7] = '{129, 48, 1,  32, {1'b0, 32'h00000080}};

        rst_n = 1'b0;
        abort = 1'b0;
        in_byte = '0;
        in_byte_valid = 1'b0;
        in_byte_last = 1'b0;
        #1;
        chk("rst_ctl", {in_byte_ready, blk_word_valid, blk_word_last, busy, done},
            5'b10000);
        chk("rst_word", blk_word, 0);
        chk("rst_len", {msg_len_bytes, last_blk_bytes}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 8; v++) begin
            msg_q.delete();
            got_q.delete();
            for (int i = 0; i < vecs[v].len; i++) msg_q.push_back(8'(i));
            if (v == 0) msg_q = '{8'h11, 8'h22, 8'h33};
            build_exp();
            send_bytes(1);
            finish_msg($sformatf("vec%0d", v), vecs[v].nwords, vecs[v].lb);
            if (got_q.size() > vecs[v].idx)
                chk($sformatf("vec%0d_point", v), got_q[vecs[v].idx], vecs[v].val);
            else
                chk($sformatf("vec%0d_point_missing", v), got_q.size(), vecs[v].idx + 1);
        end

        // Backpressure on word2 of a 12-byte message.
        msg_q.delete();
        got_q.delete();
        for (int i = 0; i < 12; i++) msg_q.push_back(8'(8'hA0 + i));
        build_exp();
        fork
            send_bytes(1);
            begin
                t = 0;
                while (got_q.size() < 2 && t < 500) begin
                    @(negedge clk);
                    t++;
                end
                force_ready = 1'b0;
                t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!blk_word_valid && t < 500);
                for (int k = 0; k < 5; k++) begin
                    chk("stall_valid", blk_word_valid, 1);
                    chk("stall_in_ready", in_byte_ready, 0);
                    @(negedge clk);
                end
                force_ready = 1'b1;
            end
        join
        finish_msg("stall", 16, 12);

        // Abort mid-message, then a 1-byte message.
        saved_len = msg_len_bytes;
        saved_lb  = last_blk_bytes;
        msg_q.delete();
        got_q.delete();
        for (int i = 0; i < 6; i++) msg_q.push_back(8'(8'h50 + i));
        send_bytes(0);
        chk("pre_abort_busy", busy, 1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_ctl", {in_byte_ready, blk_word_valid, busy, done}, 4'b1000);
        chk("abort_len", msg_len_bytes, saved_len);
        chk("abort_lb", last_blk_bytes, saved_lb);
        @(posedge clk);
        #1;
        msg_q.delete();
        got_q.delete();
        msg_q.push_back(8'hAA);
        build_exp();
        send_bytes(1);
        finish_msg("post_abort", 16, 1);
        if (got_q.size() > 0) chk("post_abort_w0", got_q[0], {1'b0, 32'h000000AA});

        // Reset while padding at word_ptr 9.
        msg_q.delete();
        got_q.delete();
        msg_q.push_back(8'h5A);
        send_bytes(1);
        t = 0;
        while (got_q.size() < 9 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("reach_pad9", got_q.size(), 9);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctl", {in_byte_ready, blk_word_valid, blk_word_last, busy, done},
            5'b10000);
        chk("mid_rst_word", blk_word, 0);
        chk("mid_rst_len", {msg_len_bytes, last_blk_bytes}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        msg_q.delete();
        got_q.delete();
        for (int i = 0; i < 5; i++) msg_q.push_back(8'(8'hC0 + i));
        build_exp();
        send_bytes(1);
        finish_msg("post_rst", 16, 5);

        // Randomized messages with input gaps and random backpressure.
        rand_ready = 1'b1;
        gap_pct    = 30;
        for (int m = 0; m < 20; m++) begin
            int len;
            len = $urandom_range(1, 150);
            msg_q.delete();
            got_q.delete();
            for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
            build_exp();
            send_bytes(1);
            finish_msg($sformatf("rnd%0d", m), ((len + 63) / 64) * 16,
                       ((len - 1) % 64) + 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
